// File: rtl/conv_stream_strided.sv
// Streaming K x K convolver with configurable stride.
// Pixels arrive in raster order, one per accepted beat (ce & act_valid).
// Window sums leave two enabled cycles after the window-completing pixel
// is accepted. The product register is followed by an adder tree and the
// output register. Frames may follow each other back to back.
module conv_stream_strided #(
    parameter int N      = 10,
    parameter int K      = 5,
    parameter int S      = 1,
    parameter int DW     = 16,
    parameter int C_SIZE = 32
) (
    input  logic                clk,
    input  logic                global_rst_n,
    input  logic                ce,
    input  logic                act_valid,
    input  logic [DW-1:0]       activation,
    input  logic                w_load,
    input  logic [K*K*DW-1:0]   weight1,
    output logic                w_err,
    output logic                busy,
    output logic [C_SIZE-1:0]   conv_op,
    output logic                valid_conv,
    output logic                end_conv
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (S > 1) ? $clog2(S) : 1;
    localparam int KK = K * K;

    localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
    localparam logic [CW-1:0] WIN_START = CW'(K - 1);
    localparam logic [PW-1:0] LAST_PH   = PW'(S - 1);

    // Parameter sanity, rejected at elaboration.
    generate
        if (K < 2) begin : g_bad_k
            $error("conv_stream_strided: K must be at least 2");
        end
        if (N < K) begin : g_bad_n
            $error("conv_stream_strided: N must be at least K");
        end
        if (S < 1) begin : g_bad_s
            $error("conv_stream_strided: S must be at least 1");
        end
        if (C_SIZE < 2 * DW) begin : g_bad_c
            $error("conv_stream_strided: C_SIZE must be at least 2*DW");
        end
        if (S >= 1 && ((N - K) % S) != 0) begin : g_bad_stride
            $error("conv_stream_strided: (N-K) must be a multiple of S");
        end
    endgenerate

    // Reset tree: asynchronous assertion, deassertion aligned to clk.
    logic [1:0] rst_sync;
    logic       rst_n;

    // Two-flop reset synchronizer. It is not gated by ce.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Position tracking.
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [PW-1:0] row_ph;
    logic [PW-1:0] col_ph;

    logic accept;
    logic at_last_col;
    logic at_last_row;
    logic at_last_pix;
    logic at_hit;
    logic w_ok;

    // Window storage and datapath.
    logic signed [DW-1:0]     lb      [K-1][N];
    logic signed [DW-1:0]     win     [K][K];
    logic signed [DW-1:0]     col_vec [K];
    logic signed [C_SIZE-1:0] prod_n  [KK];
    logic signed [C_SIZE-1:0] prod    [KK];
    logic signed [C_SIZE-1:0] sum;

    // Pipeline control and weights.
    logic              hit0;
    logic              last0;
    logic              v1;
    logic              last1;
    logic [K*K*DW-1:0] w_reg;

    // Decode the current pixel position and the weight-load guard.
    // The phase counters hold (idx-K+1) mod S once idx >= K-1, so no divider
    // is needed. A weight load is refused while a frame is open, when a pixel
    // is being accepted, or while an output is still in the pipeline.
    // NOTE: combinational blocks assign every output on every path. That
    // keeps synthesis from inferring latches.
    always_comb begin
        accept      = ce & act_valid;
        at_last_col = (col == LAST_IDX);
        at_last_row = (row == LAST_IDX);
        at_last_pix = at_last_col & at_last_row;
        at_hit      = (row >= WIN_START) && (col >= WIN_START) &&
                      (row_ph == '0) && (col_ph == '0);
        w_ok        = !busy && !accept && !hit0 && !v1 && !last0 && !last1;
    end

    // Row/column counters and stride phases. They advance on accepted beats.
    // NOTE: clocked state uses non-blocking assignments. Every flop then
    // samples values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row    <= '0;
            col    <= '0;
            row_ph <= '0;
            col_ph <= '0;
        end else if (accept) begin
            if (at_last_col) begin
                col    <= '0;
                col_ph <= '0;
                if (at_last_row) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row <= row + 1'b1;
                    if (row >= WIN_START) begin
                        row_ph <= (row_ph == LAST_PH) ? '0 : row_ph + 1'b1;
                    end else begin
                        row_ph <= '0;
                    end
                end
            end else begin
                col <= col + 1'b1;
                if (col >= WIN_START) begin
                    col_ph <= (col_ph == LAST_PH) ? '0 : col_ph + 1'b1;
                end else begin
                    col_ph <= '0;
                end
            end
        end
    end

    // Build the incoming window column.
    // Row r-K+1+i of the current column is at index i, and the new pixel is
    // the last entry.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            col_vec[i] = lb[i][col];
        end
        col_vec[K-1] = $signed(activation);
    end

    // Line buffers and the register window. They shift on accepted beats only.
    // NOTE: storage arrays have no reset. Their contents are never used
    // before being overwritten by valid pixels, so a reset would only add
    // load on the reset net.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < K - 1; i++) begin
                lb[i][col] <= col_vec[i+1];
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
                win[i][K-1] <= col_vec[i];
            end
        end
    end

    // Signed DW x DW products, sign-extended to the accumulator width.
    always_comb begin
        logic signed [2*DW-1:0] p;
        p = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                p = win[i][j] * $signed(w_reg[(i*K+j)*DW +: DW]);
                prod_n[i*K+j] = C_SIZE'(p);
            end
        end
    end

    // Stage 1: product register. It advances on every enabled cycle, so
    // bubbles do not stall the pipeline.
    always_ff @(posedge clk) begin
        if (ce) begin
            for (int k = 0; k < KK; k++) begin
                prod[k] <= prod_n[k];
            end
        end
    end

    // Stage 2 adder tree. The sum wraps modulo 2^C_SIZE.
    // NOTE: the accumulating loop variable uses blocking assignments so each
    // iteration sees the previous partial sum within the same evaluation.
    always_comb begin
        sum = '0;
        for (int k = 0; k < KK; k++) begin
            sum = sum + prod[k];
        end
    end

    // Pipeline qualifiers, output register, busy, weight capture and w_err.
    // busy covers an open frame and any last-of-frame marker still in flight.
    // The marker travelling into end_conv keeps busy high through that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit0       <= 1'b0;
            last0      <= 1'b0;
            v1         <= 1'b0;
            last1      <= 1'b0;
            valid_conv <= 1'b0;
            end_conv   <= 1'b0;
            conv_op    <= '0;
            busy       <= 1'b0;
            w_err      <= 1'b0;
            w_reg      <= '0;
        end else if (ce) begin
            hit0       <= accept & at_hit;
            last0      <= accept & at_last_pix;
            v1         <= hit0;
            last1      <= last0;
            valid_conv <= v1;
            end_conv   <= last1;
            if (v1) begin
                conv_op <= sum;
            end
            busy  <= accept | (row != '0) | (col != '0) | last0 | last1;
            w_err <= w_load & ~w_ok;
            if (w_load && w_ok) begin
                w_reg <= weight1;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_strided.sv
// Directed bench for conv_stream_strided.
// Instance a uses the default geometry: N=10, K=5, S=1.
// Instance b uses the strided geometry: N=9, K=3, S=2.
module tb_conv_stream_strided;

    logic clk;
    logic global_rst_n;

    // Instance a signals
    logic          ce_a, act_valid_a, w_load_a;
    logic [15:0]   activation_a;
    logic [399:0]  weight1_a;
    logic          w_err_a, busy_a, valid_a, end_a;
    logic [31:0]   conv_op_a;

    // Instance b signals
    logic          ce_b, act_valid_b, w_load_b;
    logic [15:0]   activation_b;
    logic [143:0]  weight1_b;
    logic          w_err_b, busy_b, valid_b, end_b;
    logic [31:0]   conv_op_b;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int acc44 = 0;
    int first_a_cyc = -1;
    int hold_err_a = 0;
    logic ce_edge_a = 1'b1;
    logic vc_prev_a = 1'b0;

    logic [31:0] qa_op[$];
    logic        qa_end[$];
    logic [31:0] qb_op[$];
    logic        qb_end[$];

    conv_stream_strided #(.N(10), .K(5), .S(1), .DW(16), .C_SIZE(32)) dut_a (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .ce           (ce_a),
        .act_valid    (act_valid_a),
        .activation   (activation_a),
        .w_load       (w_load_a),
        .weight1      (weight1_a),
        .w_err        (w_err_a),
        .busy         (busy_a),
        .conv_op      (conv_op_a),
        .valid_conv   (valid_a),
        .end_conv     (end_a)
    );

    conv_stream_strided #(.N(9), .K(3), .S(2), .DW(16), .C_SIZE(32)) dut_b (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .ce           (ce_b),
        .act_valid    (act_valid_b),
        .activation   (activation_b),
        .w_load       (w_load_b),
        .weight1      (weight1_b),
        .w_err        (w_err_b),
        .busy         (busy_b),
        .conv_op      (conv_op_b),
        .valid_conv   (valid_b),
        .end_conv     (end_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter and the ce value seen by each edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        ce_edge_a = ce_a;
    end

    // Output collectors: an output is consumed on an edge where ce is high
    always @(negedge clk) begin
        if (ce_a && valid_a) begin
            qa_op.push_back(conv_op_a);
            qa_end.push_back(end_a);
            if (first_a_cyc < 0) first_a_cyc = cyc;
        end
        if (!ce_edge_a && (valid_a !== vc_prev_a)) hold_err_a = hold_err_a + 1;
        vc_prev_a = valid_a;
        if (ce_b && valid_b) begin
            qb_op.push_back(conv_op_b);
            qb_end.push_back(end_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic load_a(input logic [15:0] w);
        for (int i = 0; i < 25; i++) weight1_a[i*16 +: 16] = w;
        w_load_a = 1'b1;
        @(posedge clk); #1;
        check("load_a_w_err", {31'd0, w_err_a}, 32'd0);
        w_load_a = 1'b0;
    endtask

    // Feed npix pixels to instance a. mode 0 sends cval, and mode 1 sends
    // the pixel index modulo 100.
    task automatic drive_a(input int npix, input int mode, input logic [15:0] cval,
                           input int bub_pct, input int wload_at);
        int p;
        bit pend0;
        p = 0;
        pend0 = 0;
        while (p < npix) begin
            @(posedge clk); #1;
            if (pend0) begin
                check("w_err_after_pulse", {31'd0, w_err_a}, 32'd0);
                pend0 = 0;
            end
            if (w_load_a) begin
                check("w_err_pulse", {31'd0, w_err_a}, 32'd1);
                w_load_a = 1'b0;
                pend0 = 1;
            end
            ce_a         = (bub_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= 20);
            act_valid_a  = (bub_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= bub_pct);
            activation_a = (mode != 0) ? 16'(p % 100) : cval;
            if (p == wload_at) w_load_a = 1'b1;
            if (ce_a && act_valid_a) begin
                if (p == 44) acc44 = cyc + 1;
                p++;
            end
        end
        @(posedge clk); #1;
        if (w_load_a) begin
            check("w_err_pulse", {31'd0, w_err_a}, 32'd1);
            w_load_a = 1'b0;
        end
        ce_a = 1'b1;
        act_valid_a = 1'b0;
    endtask

    // Wait for n outputs from a, then check count, values and end flags.
    task automatic check_a(input string name, input int n, input int mode,
                           input int scale, input logic [31:0] cval);
        int t;
        int o36;
        int r0;
        int c0;
        logic [31:0] exp_v;
        t = 0;
        while (qa_op.size() < n && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({name, "_count"}, qa_op.size(), n);
        for (int o = 0; o < n && o < qa_op.size(); o++) begin
            o36 = o % 36;
            r0 = o36 / 6;
            c0 = o36 % 6;
            exp_v = (mode != 0) ? 32'(scale * (250 * r0 + 25 * c0 + 550)) : cval;
            check($sformatf("%s_op[%0d]", name, o), qa_op[o], exp_v);
            check($sformatf("%s_end[%0d]", name, o), {31'd0, qa_end[o]},
                  {31'd0, (o36 == 35)});
        end
        check({name, "_busy_idle"}, {31'd0, busy_a}, 32'd0);
    endtask

    task automatic clear_a();
        qa_op.delete();
        qa_end.delete();
        first_a_cyc = -1;
    endtask

    initial begin
        int t;
        global_rst_n = 1'b0;
        ce_a = 1'b1; act_valid_a = 1'b0; activation_a = '0; w_load_a = 1'b0; weight1_a = '0;
        ce_b = 1'b1; act_valid_b = 1'b0; activation_b = '0; w_load_b = 1'b0; weight1_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_conv_op", conv_op_a, 32'd0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_end", {31'd0, end_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_w_err", {31'd0, w_err_a}, 32'd0);
        global_rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Test 1: unit weights, constant 1, no bubbles
        for (int i = 0; i < 9; i++) weight1_b[i*16 +: 16] = 16'h0001;
        w_load_b = 1'b1;
        load_a(16'h0001);
        check("load_b_w_err", {31'd0, w_err_b}, 32'd0);
        w_load_b = 1'b0;
        clear_a();
        drive_a(100, 0, 16'h0001, 0, -1);
        check_a("t1", 36, 0, 1, 32'h0000_0019);
        check("t1_latency", 32'(first_a_cyc), 32'(acc44 + 2));

        // Test 2: stride 2 on instance b, pixel index stimulus
        for (int p = 0; p < 81; p++) begin
            @(posedge clk); #1;
            act_valid_b = 1'b1;
            activation_b = 16'(p);
        end
        @(posedge clk); #1;
        act_valid_b = 1'b0;
        t = 0;
        while (qb_op.size() < 16 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("t2_count", qb_op.size(), 32'd16);
        for (int o = 0; o < 16 && o < qb_op.size(); o++) begin
            check($sformatf("t2_op[%0d]", o), qb_op[o],
                  32'(81 * (2 * (o / 4)) + 9 * (2 * (o % 4)) + 90));
            check($sformatf("t2_end[%0d]", o), {31'd0, qb_end[o]}, {31'd0, (o == 15)});
        end
        check("t2_busy_idle", {31'd0, busy_b}, 32'd0);

        // Test 3: signed arithmetic, weights -1 and activation 2
        load_a(16'hFFFF);
        clear_a();
        drive_a(100, 0, 16'h0002, 0, -1);
        check_a("t3", 36, 0, 1, 32'hFFFF_FFCE);

        // Test 4: bubbles and ce dropouts, index stimulus
        load_a(16'h0001);
        clear_a();
        hold_err_a = 0;
        drive_a(100, 1, 16'h0000, 40, -1);
        check_a("t4", 36, 1, 1, 32'd0);
        check("t4_ce_hold", 32'(hold_err_a), 32'd0);

        // Test 5: back-to-back frames. A mid-frame load is refused.
        for (int i = 0; i < 25; i++) weight1_a[i*16 +: 16] = 16'h0002;
        clear_a();
        drive_a(200, 1, 16'h0000, 0, 150);
        check_a("t5a", 72, 1, 1, 32'd0);
        load_a(16'h0002);
        clear_a();
        drive_a(100, 1, 16'h0000, 0, -1);
        check_a("t5b", 36, 1, 2, 32'd0);

        // Test 6: reset in the middle of a frame, then restart
        drive_a(60, 0, 16'h0001, 0, -1);
        check("t6_busy_mid", {31'd0, busy_a}, 32'd1);
        #2;
        global_rst_n = 1'b0;
        #1;
        check("t6_rst_conv_op", conv_op_a, 32'd0);
        check("t6_rst_valid", {31'd0, valid_a}, 32'd0);
        check("t6_rst_end", {31'd0, end_a}, 32'd0);
        check("t6_rst_busy", {31'd0, busy_a}, 32'd0);
        check("t6_rst_w_err", {31'd0, w_err_a}, 32'd0);
        @(posedge clk); #1;
        global_rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        load_a(16'h0001);
        clear_a();
        drive_a(100, 0, 16'h0001, 0, -1);
        check_a("t6", 36, 0, 1, 32'h0000_0019);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_stream_strided.md
Name: conv_stream_strided

Overview:
- Parametrised successor of the single-channel streaming convolver.
- Accepts an N x N activation frame in raster order, one pixel per accepted beat, and a K x K weight set. Emits signed K x K window sums at a configurable stride, with a fixed pipeline latency.
- Adds over the previous generation:
  - per-beat input qualification with bubble tolerance;
  - stride;
  - guarded weight reload;
  - back-to-back frames without reset.
- Sits between the activation streamer and the pooling/ReLU stage of the CNN datapath.

Parameters:
- N, 10, frame width = frame height in pixels (>= K).
- K, 5, kernel size (>= 2).
- S, 1, stride in both dimensions (>= 1). Constraint: (N-K) mod S == 0, checked by an elaboration-time assertion.
- DW, 16, activation/weight width, signed two's complement.
- C_SIZE, 32, accumulator/output width (>= 2*DW).

Ports:
- clk  in  1  rising-edge clock.
- global_rst_n  in  1  reset: asynchronous assert, synchronous deassert, active-low.
- ce  in  1  global clock enable. Low freezes all state, pipeline and outputs.
- act_valid  in  1  activation beat qualifier. A beat is accepted when ce & act_valid.
- activation  in  DW  pixel value.
- w_load  in  1  request to capture weight1.
- weight1  in  K*K*DW  weights. Index i = row*K+col occupies bits [i*DW +: DW].
- w_err  out  1  one-cycle pulse: w_load was rejected.
- busy  out  1  high from the first accepted pixel of a frame until its last output is issued.
- conv_op  out  C_SIZE  signed window sum.
- valid_conv  out  1  conv_op qualifier, one cycle per output.
- end_conv  out  1  high together with the last valid_conv of a frame.

Behaviour:
- Reset, asynchronous and active-low:
  - conv_op=0, valid_conv=0, end_conv=0, busy=0, w_err=0.
  - Row/column counters = 0. Pipeline valid bits cleared. Weight register cleared to 0.
  - Line-buffer contents are don't-care.
  - Reset mid-frame abandons the frame. The next accepted pixel is (row 0, col 0).
- Pixel tracking:
  - col increments on each accepted beat; it wraps at N-1 and increments row.
  - After pixel (N-1, N-1), both counters return to 0 and the next accepted beat starts a new frame. No idle gap is required.
- Window storage: K-1 line buffers of N entries each, plus a K x K register window, all shifted only on accepted beats.
- Output condition for the accepted pixel (r, c):
  - r >= K-1 and c >= K-1, and
  - (r-K+1) mod S == 0 and (c-K+1) mod S == 0.
  - Track stride with phase counters, not dividers.
  - Outputs per frame = ((N-K)/S+1)^2.
- Arithmetic:
  - Each product is signed DW x DW, sign-extended to C_SIZE.
  - The sum of the K*K products wraps modulo 2^C_SIZE, with no saturation.
  - Window element (i, j) multiplies weight index i*K+j, where (0, 0) is the top-left (oldest) pixel.
- Latency: valid_conv asserts exactly 2 enabled cycles after the clock edge that accepted the window-completing pixel.
  - Stage 1: product register.
  - Stage 2: adder tree plus output register.
  - Bubbles (act_valid=0) do not stall the pipeline.
  - ce=0 stalls everything, including valid_conv, which holds its value.
- valid_conv: a one-cycle pulse per output. conv_op holds its last value between pulses.
- end_conv:
  - Asserts on the cycle carrying the output for the window ending at (N-1, N-1).
  - busy deasserts on the following cycle, unless a new frame has already started.
- Weight load (w_load & ce):
  - Honoured only when busy=0, no pixel of the current frame has been accepted, and no output is in flight. weight1 is then captured on that edge.
  - Otherwise the weights are unchanged and w_err pulses for one cycle.
  - w_load in the same cycle as an accepted first pixel of a frame is rejected.
- Simultaneous end of one frame and first pixel of the next: both are handled. busy stays high and outputs remain in order.

Test Plan:
- N=10, K=5, S=1; all weights 0x0001; activation constant 0x0001 -> 36 pulses of conv_op=0x00000019; end_conv on the 36th pulse only; first valid_conv 2 cycles after pixel index 44 is accepted.
- N=9, K=3, S=2; weights all 1; activation = pixel index 0..80 -> 16 outputs; the first is the window at rows 0-2, cols 0-2, giving 0+1+2+9+10+11+18+19+20=0x5A; strided positions are verified against a reference model.
- Signed: all weights 0xFFFF (-1), activation 0x0002, N=10, K=5 -> every conv_op=0xFFFFFFCE (-50).
- Random act_valid bubbles (~40%) plus ce dropouts on the first test -> identical output values and order; valid_conv never asserts while ce=0.
- Two back-to-back frames with no gap; w_load mid-frame -> w_err pulse, weights unchanged; w_load between frames -> new weights used for the second frame.
- Assert global_rst_n low mid-frame -> all outputs are 0 immediately (asynchronously); restart the frame -> correct 36 outputs.
